// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// hands a single fetched instruction to the decoder, trapping on bad targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code
);

  // state  | meaning
  // IDLE   | post-reset, one cycle before the first request
  // REQ    | imem_req pulse at pc
  // WAIT   | awaiting imem_valid, counting toward timeout
  // OUT    | instr/instr_pc presented to the decoder
  // HALT   | stopped by ECALL/EBREAK, exits only on reset
  // ERR    | fetch fault, exits only on reset
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_OUT, S_HALT, S_ERR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        drop_q, drop_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  fault_code_q, fault_code_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      drop_q       <= 1'b0;
      wait_cnt_q   <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      drop_q       <= drop_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    drop_d       = drop_q;
    wait_cnt_d   = wait_cnt_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (imem_valid) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = S_OUT;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          fault_code_d = FC_TIMEOUT;
          state_d      = S_ERR;
        end else if (redirect_valid) begin
          // Response for the old pc is still owed; discard it when it lands.
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end

      S_OUT: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) begin
            fault_code_d = FC_MISALIGN;
            state_d      = S_ERR;
          end else begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end
        end else if (halt) begin
          state_d = S_HALT;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end

      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + 32'd4;
  assign instr_valid = (state_q == S_OUT);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_ERR);
  assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of OUT-state decisions plus
// hand-written multi-cycle sequences against a latency-programmable memory.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .halt(halt),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .halted(halted),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model: responds mem_lat cycles after the req cycle (0 = never)
  int          mem_lat = 1;
  bit          mem_const = 1'b0;
  int          pend = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_const ? 32'h0000_0013 : (a ^ 32'h5A00_0013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
      end
    end
    if (imem_req === 1'b1 && mem_lat > 0) begin
      pend      = mem_lat;
      pend_addr = imem_addr;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    halt = 1'b0;
    step();
    pend = 0;
    imem_valid = 1'b0;
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst fault_code", 32'(fault_code), 32'd0);
    chk("rst imem_addr", imem_addr, RPC);
    rst_n = 1'b1;
  endtask

  task automatic wait_iv(input int max_cycles);
    bit ok = 1'b0;
    for (int k = 0; k < max_cycles && !ok; k++) begin
      step();
      if (instr_valid === 1'b1) ok = 1'b1;
    end
    chk("wait instr_valid within budget", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_halted;
    logic        e_fault;
    logic [1:0]  e_fc;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 32'h0,           1'b0, 1'b0, 1'b1, RPC + 32'd4,     1'b0, 1'b0, 1'b0, 2'b00};
    vt[1] = '{1'b0, 32'h0,           1'b0, 1'b1, 1'b0, RPC,             1'b1, 1'b0, 1'b0, 2'b00};
    vt[2] = '{1'b0, 32'h0,           1'b1, 1'b0, 1'b0, RPC,             1'b0, 1'b1, 1'b0, 2'b00};
    vt[3] = '{1'b0, 32'h0,           1'b1, 1'b1, 1'b0, RPC,             1'b0, 1'b1, 1'b0, 2'b00};
    vt[4] = '{1'b1, 32'h0100_0100,   1'b0, 1'b0, 1'b1, 32'h0100_0100,   1'b0, 1'b0, 1'b0, 2'b00};
    vt[5] = '{1'b1, 32'h0100_0100,   1'b1, 1'b1, 1'b1, 32'h0100_0100,   1'b0, 1'b0, 1'b0, 2'b00};
    vt[6] = '{1'b1, 32'h0100_0102,   1'b0, 1'b0, 1'b0, RPC,             1'b0, 1'b0, 1'b1, 2'b01};
    vt[7] = '{1'b1, 32'h0100_0102,   1'b1, 1'b0, 1'b0, RPC,             1'b0, 1'b0, 1'b1, 2'b01};
    vt[8] = '{1'b1, 32'h0100_0101,   1'b0, 1'b1, 1'b0, RPC,             1'b0, 1'b0, 1'b1, 2'b01};
    vt[9] = '{1'b1, 32'h0000_0003,   1'b1, 1'b1, 1'b0, RPC,             1'b0, 1'b0, 1'b1, 2'b01};

    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; halt = 1'b0;

    // steady state, constant NOP memory
    mem_const = 1'b1; mem_lat = 1;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("seq c%0d imem_req", i), 32'(imem_req), 32'((i % 3) == 1));
      chk($sformatf("seq c%0d instr_valid", i), 32'(instr_valid), 32'((i % 3) == 0));
      if ((i % 3) == 1)
        chk($sformatf("seq c%0d imem_addr", i), imem_addr, RPC + 32'(4 * (i / 3)));
      if ((i % 3) == 0) begin
        chk($sformatf("seq c%0d instr_pc", i), instr_pc, RPC + 32'(4 * (i / 3 - 1)));
        chk($sformatf("seq c%0d pc_plus4", i), pc_plus4, RPC + 32'(4 * (i / 3)));
        chk($sformatf("seq c%0d instr", i), instr, 32'h0000_0013);
      end
    end
    mem_const = 1'b0;

    // OUT-state decision table
    for (int i = 0; i < 10; i++) begin
      do_reset();
      step(); step(); step();
      chk($sformatf("vec%0d in OUT", i), 32'(instr_valid), 32'd1);
      chk($sformatf("vec%0d instr", i), instr, mem_word(RPC));
      redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
      halt = vt[i].hlt; stall = vt[i].stl;
      step();
      redirect_valid = 1'b0; halt = 1'b0; stall = 1'b0;
      chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
      chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vt[i].e_halted));
      chk($sformatf("vec%0d fault", i), 32'(fault), 32'(vt[i].e_fault));
      chk($sformatf("vec%0d fault_code", i), 32'(fault_code), 32'(vt[i].e_fc));
    end

    // stall holds for 5 cycles, release advances
    do_reset();
    wait_iv(8);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d instr_valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("stall%0d imem_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("stall%0d instr_pc", k), instr_pc, RPC);
      chk($sformatf("stall%0d instr", k), instr, mem_word(RPC));
    end
    stall = 1'b0;
    step();
    chk("stall release imem_req", 32'(imem_req), 32'd1);
    chk("stall release imem_addr", imem_addr, RPC + 32'd4);

    // redirect in OUT, then in WAIT with late data that must be dropped
    mem_lat = 3;
    do_reset();
    wait_iv(10);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
    step();
    redirect_valid = 1'b0;
    chk("redir out imem_req", 32'(imem_req), 32'd1);
    chk("redir out imem_addr", imem_addr, 32'h0100_0100);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0200;
    step();
    redirect_valid = 1'b0;
    chk("redir wait no req", 32'(imem_req), 32'd0);
    chk("redir wait no iv", 32'(instr_valid), 32'd0);
    step();
    chk("late data cycle no iv", 32'(instr_valid), 32'd0);
    chk("late data present", 32'(imem_valid), 32'd1);
    step();
    chk("dropped refetch imem_req", 32'(imem_req), 32'd1);
    chk("dropped refetch imem_addr", imem_addr, 32'h0100_0200);
    chk("dropped refetch no iv", 32'(instr_valid), 32'd0);
    wait_iv(10);
    chk("after drop instr_pc", instr_pc, 32'h0100_0200);
    chk("after drop instr", instr, mem_word(32'h0100_0200));

    // redirect on the same cycle as imem_valid
    mem_lat = 1;
    do_reset();
    wait_iv(8);
    step();
    step();
    chk("same-cycle data present", 32'(imem_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0300;
    step();
    redirect_valid = 1'b0;
    chk("same-cycle no iv", 32'(instr_valid), 32'd0);
    chk("same-cycle imem_req", 32'(imem_req), 32'd1);
    chk("same-cycle imem_addr", imem_addr, 32'h0100_0300);

    // misaligned redirect: absorbing fault, no further requests
    do_reset();
    wait_iv(8);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0102; halt = 1'b1;
    step();
    redirect_valid = 1'b0; halt = 1'b0;
    redirect_pc = 32'h0100_0200;
    for (int k = 0; k < 6; k++) begin
      redirect_valid = (k == 2);
      step();
      chk($sformatf("err%0d imem_req", k), 32'(imem_req), 32'd0);
      chk($sformatf("err%0d fault", k), 32'(fault), 32'd1);
      chk($sformatf("err%0d halted", k), 32'(halted), 32'd0);
      chk($sformatf("err%0d fault_code", k), 32'(fault_code), 32'd1);
    end
    redirect_valid = 1'b0;

    // halt with stall, redirects ignored, reset restarts fetch
    do_reset();
    wait_iv(8);
    halt = 1'b1; stall = 1'b1;
    step();
    halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("halt%0d halted", k), 32'(halted), 32'd1);
      chk($sformatf("halt%0d instr_valid", k), 32'(instr_valid), 32'd0);
      chk($sformatf("halt%0d imem_req", k), 32'(imem_req), 32'd0);
    end
    redirect_valid = 1'b0;
    do_reset();
    chk("post-halt reset halted", 32'(halted), 32'd0);
    step();
    chk("post-halt refetch req", 32'(imem_req), 32'd1);
    chk("post-halt refetch addr", imem_addr, RPC);

    // timeout: ERR exactly 16 cycles after WAIT entry
    mem_lat = 0;
    do_reset();
    step();
    chk("timeout req", 32'(imem_req), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("timeout wait%0d fault", k), 32'(fault), 32'd0);
    end
    step();
    chk("timeout fault", 32'(fault), 32'd1);
    chk("timeout fault_code", 32'(fault_code), 32'd2);
    step();
    chk("timeout sticky fault", 32'(fault), 32'd1);
    chk("timeout no req", 32'(imem_req), 32'd0);

    // pc wrap from 0xFFFF_FFFC
    mem_lat = 1;
    do_reset();
    wait_iv(8);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap req addr", imem_addr, 32'hFFFF_FFFC);
    wait_iv(8);
    chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4, 32'h0000_0000);
    step();
    chk("wrap next req", 32'(imem_req), 32'd1);
    chk("wrap next addr", imem_addr, 32'h0000_0000);
    chk("wrap no fault", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
